// File: rtl/mqc_capture_ctrl_pkg.sv
// Shared types and header helpers for the diagnostics capture/readout controller.
package mqc_pkg;

  typedef enum logic [1:0] {SCAN, CAPTURE, HOLD, READOUT} mqc_state_t;

  localparam logic [7:0] MQC_HDR_SCAN = 8'h5C;
  localparam logic [7:0] MQC_HDR_CAP  = 8'hCA;

  function automatic logic [31:0] mqc_hdr(input logic [7:0] hdr_type,
                                          input logic [7:0] idx,
                                          input logic [15:0] magic);
    return {hdr_type, idx, magic};
  endfunction

endpackage

// File: rtl/mqc_capture_ctrl_if.sv
// Trigger, channel, readout-request and stream-out signals of the capture controller.
interface mqc_capture_ctrl_if #(
  parameter int pDAT_W  = 32,
  parameter int pCH_NUM = 17
);
  logic                        itrig;
  logic [pDAT_W-1:0]           itrig_data;
  logic [pCH_NUM*pDAT_W-1:0]   ich_data;
  logic                        istart_rd;
  logic                        ird_ready;
  logic                        ord_valid;
  logic [pDAT_W-1:0]           ord_data;
  logic                        ord_last;
  logic                        ocap_ready;
  logic                        obusy;
  logic [15:0]                 odrop_cnt;

  modport slave (
    input  itrig, itrig_data, ich_data, istart_rd, ird_ready,
    output ord_valid, ord_data, ord_last, ocap_ready, obusy, odrop_cnt
  );

  modport master (
    output itrig, itrig_data, ich_data, istart_rd, ird_ready,
    input  ord_valid, ord_data, ord_last, ocap_ready, obusy, odrop_cnt
  );
endinterface

// File: rtl/mqc_capture_ctrl_ram.sv
// Simple dual-port record buffer: one write port, one read port with 1-cycle latency.
module buffer_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en_wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en_wr) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mqc_capture_ctrl.sv
// Scan/capture record controller: fills a record buffer from status channels or a
// triggered burst, then streams the frozen record out through a 2-entry skid buffer.
module mqc_capture_ctrl
  import mqc_pkg::*;
#(
  parameter int          pDAT_W     = 32,
  parameter int          pCH_NUM    = 17,
  parameter int          pCAP_DEPTH = 200000,
  parameter int          pADDR_W    = 18,
  parameter int          pDWELL     = 3,
  parameter logic [15:0] pMAGIC     = 16'h0AFA
) (
  input logic              iclk,
  input logic              ireset,
  mqc_capture_ctrl_if.slave bus
);

  localparam int DW = (pDWELL > 1) ? $clog2(pDWELL) : 1;
  localparam logic [pADDR_W-1:0] SCAN_LEN_M1 = pADDR_W'(2*pCH_NUM - 1);
  localparam logic [pADDR_W-1:0] CAP_LEN_M1  = pADDR_W'(pCAP_DEPTH);

  if (pDAT_W < 32) begin : g_bad_dat_w
    $error("pDAT_W must be >= 32");
  end
  if (pCH_NUM < 1 || pCH_NUM > 255) begin : g_bad_ch_num
    $error("pCH_NUM must be in 1..255");
  end
  if (pDWELL < 2) begin : g_bad_dwell
    $error("pDWELL must be >= 2");
  end
  if (longint'(pCAP_DEPTH) + 1 > (64'd1 << pADDR_W) ||
      longint'(2*pCH_NUM) > (64'd1 << pADDR_W)) begin : g_bad_addr_w
    $error("pADDR_W too small for record length");
  end

  mqc_state_t          state;
  logic [7:0]          ch_idx;
  logic [DW-1:0]       dwell_cnt;
  logic [pADDR_W-1:0]  cap_cnt, len_m1, rd_ptr;
  logic                issue_done, inflight, inflight_last;
  logic                out_valid, out_last, sk_valid, sk_last;
  logic [pDAT_W-1:0]   out_data, sk_data;
  logic                cap_ready;
  logic [15:0]         drop_cnt;

  logic                wr_en;
  logic [pADDR_W-1:0]  wr_addr;
  logic [pDAT_W-1:0]   wr_data, rd_data;
  logic                pop, rd_issue;
  logic [1:0]          occupancy;

  // A trigger in the same cycle abandons the scan slot, so no scan write then.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state)
      SCAN: begin
        if (!bus.itrig && !cap_ready && dwell_cnt == '0) begin
          wr_en   = 1'b1;
          wr_addr = pADDR_W'({ch_idx, 1'b0});
          wr_data = pDAT_W'(mqc_hdr(MQC_HDR_SCAN, ch_idx, pMAGIC));
        end else if (!bus.itrig && !cap_ready && dwell_cnt == DW'(1)) begin
          wr_en   = 1'b1;
          wr_addr = pADDR_W'({ch_idx, 1'b1});
          wr_data = bus.ich_data[int'(ch_idx)*pDAT_W +: pDAT_W];
        end
      end
      CAPTURE: begin
        wr_en   = 1'b1;
        wr_addr = cap_cnt;
        wr_data = (cap_cnt == '0) ? pDAT_W'(mqc_hdr(MQC_HDR_CAP, 8'h00, pMAGIC))
                                  : bus.itrig_data;
      end
      default: ;
    endcase
  end

  // Issue a read only when the skid pair plus the word in flight cannot overflow.
  always_comb begin
    pop       = out_valid && bus.ird_ready;
    occupancy = 2'(out_valid) + 2'(sk_valid) + 2'(inflight);
    rd_issue  = (state == READOUT) && !issue_done && (occupancy <= 2'd1 || pop);
  end

  buffer_ram #(.DATA_W(pDAT_W), .ADDR_W(pADDR_W)) u_ram (
    .clk     (iclk),
    .en_wr   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state         <= SCAN;
      ch_idx        <= '0;
      dwell_cnt     <= '0;
      cap_cnt       <= '0;
      len_m1        <= '0;
      rd_ptr        <= '0;
      issue_done    <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      sk_valid      <= 1'b0;
      sk_data       <= '0;
      sk_last       <= 1'b0;
      cap_ready     <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      if (bus.itrig && state != SCAN && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      case (state)
        SCAN: begin
          if (bus.itrig) begin
            state   <= CAPTURE;
            cap_cnt <= '0;
          end else if (bus.istart_rd) begin
            state      <= READOUT;
            len_m1     <= SCAN_LEN_M1;
            rd_ptr     <= '0;
            issue_done <= 1'b0;
          end else if (dwell_cnt == DW'(pDWELL - 1)) begin
            dwell_cnt <= '0;
            ch_idx    <= (ch_idx == 8'(pCH_NUM - 1)) ? '0 : ch_idx + 8'd1;
          end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
          end
        end
        CAPTURE: begin
          if (cap_cnt == CAP_LEN_M1) begin
            state     <= HOLD;
            cap_ready <= 1'b1;
          end else begin
            cap_cnt <= cap_cnt + pADDR_W'(1);
          end
        end
        HOLD: begin
          if (bus.istart_rd) begin
            state      <= READOUT;
            len_m1     <= CAP_LEN_M1;
            rd_ptr     <= '0;
            issue_done <= 1'b0;
          end
        end
        READOUT: begin
          if (rd_issue) begin
            rd_ptr        <= rd_ptr + pADDR_W'(1);
            inflight_last <= (rd_ptr == len_m1);
            if (rd_ptr == len_m1) issue_done <= 1'b1;
          end
          inflight <= rd_issue;
          if (inflight && pop) begin
            if (sk_valid) begin
              out_data <= sk_data;
              out_last <= sk_last;
              sk_data  <= rd_data;
              sk_last  <= inflight_last;
            end else begin
              out_data <= rd_data;
              out_last <= inflight_last;
            end
          end else if (inflight) begin
            if (!out_valid) begin
              out_valid <= 1'b1;
              out_data  <= rd_data;
              out_last  <= inflight_last;
            end else begin
              sk_valid <= 1'b1;
              sk_data  <= rd_data;
              sk_last  <= inflight_last;
            end
          end else if (pop) begin
            out_valid <= sk_valid;
            out_data  <= sk_data;
            out_last  <= sk_last;
            sk_valid  <= 1'b0;
          end
          if (pop && out_last) begin
            state     <= SCAN;
            ch_idx    <= '0;
            dwell_cnt <= '0;
            cap_ready <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            sk_valid  <= 1'b0;
            inflight  <= 1'b0;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  assign bus.ord_valid  = out_valid;
  assign bus.ord_data   = out_data;
  assign bus.ord_last   = out_last;
  assign bus.ocap_ready = cap_ready;
  assign bus.obusy      = (state == CAPTURE) || (state == READOUT);
  assign bus.odrop_cnt  = drop_cnt;

endmodule

// File: tb/tb_mqc_capture_ctrl.sv
// Randomised bench for mqc_capture_ctrl checked against a record-level model of
// scan/capture/readout behaviour, plus literal expectations for the key records.
module tb_mqc_capture_ctrl;

  localparam int CH = 4, DEPTH = 8, DWELL = 3, AW = 4;
  localparam logic [15:0] MAGIC = 16'h0AFA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mqc_capture_ctrl_if #(.pDAT_W(32), .pCH_NUM(CH)) bus();

  mqc_capture_ctrl #(
    .pDAT_W(32), .pCH_NUM(CH), .pCAP_DEPTH(DEPTH), .pADDR_W(AW),
    .pDWELL(DWELL), .pMAGIC(MAGIC)
  ) dut (
    .iclk   (clk),
    .ireset (rst_n),
    .bus    (bus)
  );

  typedef enum {M_SCAN, M_CAP, M_HOLD, M_READ} mode_t;

  mode_t       mode = M_SCAN;
  int          capPhase = 0;
  int          rdAge = 0;
  logic        capReady = 1'b0;
  logic [15:0] drops = 16'd0;
  logic [31:0] capRec[$];
  logic [32:0] expQ[$];
  logic [31:0] gotQ[$];
  bit          endPending = 0, allReady = 0, prevStall = 0, randReady = 0;
  logic [31:0] prevData = '0;
  logic        prevLast = 1'b0;
  int          checks = 0, failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic startRead(input bit fromCapture);
    logic [31:0] words[$];
    if (fromCapture) words = capRec;
    else
      for (int k = 0; k < CH; k++) begin
        words.push_back({8'h5C, 8'(k), MAGIC});
        words.push_back(32'hC0DE_0000 + 32'(k));
      end
    expQ.delete();
    for (int i = 0; i < words.size(); i++)
      expQ.push_back({(i == words.size() - 1), words[i]});
    gotQ.delete();
    mode = M_READ;
    rdAge = 0;
    allReady = 1;
  endtask

  // Record-level model: which record exists and what a readout must deliver.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode = M_SCAN; capReady = 1'b0; drops = 16'd0; endPending = 0; rdAge = 0;
      expQ.delete(); capRec.delete();
    end else begin
      if (bus.itrig && mode != M_SCAN && drops != 16'hFFFF) drops = drops + 16'd1;
      rdAge++;
      case (mode)
        M_SCAN: begin
          if (bus.itrig) begin
            mode = M_CAP; capPhase = 0;
            capRec.delete();
            capRec.push_back({8'hCA, 8'h00, MAGIC});
          end else if (bus.istart_rd) startRead(0);
        end
        M_CAP: begin
          if (capPhase > 0) capRec.push_back(bus.itrig_data);
          if (capPhase == DEPTH) begin mode = M_HOLD; capReady = 1'b1; end
          capPhase++;
        end
        M_HOLD: if (bus.istart_rd) startRead(1);
        M_READ: if (endPending) begin mode = M_SCAN; capReady = 1'b0; endPending = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_valid", 32'(bus.ord_valid), 0);
      checkOutput("rst_busy", 32'(bus.obusy), 0);
      checkOutput("rst_drops", 32'(bus.odrop_cnt), 0);
      prevStall = 0;
    end else begin
      checkOutput("obusy", 32'(bus.obusy), 32'(mode == M_CAP || mode == M_READ));
      checkOutput("ocap_ready", 32'(bus.ocap_ready), 32'(capReady));
      checkOutput("odrop_cnt", 32'(bus.odrop_cnt), 32'(drops));
      if (mode != M_READ) begin
        checkOutput("idle_valid", 32'(bus.ord_valid), 0);
        prevStall = 0;
      end else begin
        if (rdAge < 2) checkOutput("early_valid", 32'(bus.ord_valid), 0);
        else if (rdAge == 2) checkOutput("first_valid", 32'(bus.ord_valid), 1);
        else if (allReady && expQ.size() > 0) checkOutput("gap_valid", 32'(bus.ord_valid), 1);
        if (prevStall) begin
          checkOutput("stall_valid", 32'(bus.ord_valid), 1);
          checkOutput("stall_data", bus.ord_data, prevData);
          checkOutput("stall_last", 32'(bus.ord_last), 32'(prevLast));
        end
        if (bus.ord_valid) begin
          if (expQ.size() == 0) checkOutput("extra_word", 32'(bus.ord_valid), 0);
          else begin
            checkOutput("rd_data", bus.ord_data, expQ[0][31:0]);
            checkOutput("rd_last", 32'(bus.ord_last), 32'(expQ[0][32]));
            if (bus.ird_ready) begin
              gotQ.push_back(bus.ord_data);
              void'(expQ.pop_front());
              if (expQ.size() == 0) endPending = 1;
            end
          end
        end
        if (!bus.ird_ready) allReady = 0;
        prevStall = bus.ord_valid && !bus.ird_ready;
        prevData  = bus.ord_data;
        prevLast  = bus.ord_last;
      end
    end
  end

  task automatic applyStimulus(input bit trig, input bit start, input logic [31:0] tdata);
    @(posedge clk);
    #1;
    bus.itrig      = trig;
    bus.istart_rd  = start;
    bus.itrig_data = tdata;
    bus.ird_ready  = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, $urandom);
  endtask

  task automatic waitScan(input string name);
    int n = 0;
    applyStimulus(0, 0, $urandom);
    while (mode != M_SCAN && n < 300) begin
      applyStimulus(0, 0, $urandom);
      n++;
    end
    checkOutput(name, 32'(mode == M_SCAN), 1);
  endtask

  task automatic capture(input bit counting);
    applyStimulus(1, 0, $urandom);
    for (int k = 1; k <= DEPTH + 4; k++)
      applyStimulus(0, 0, counting ? 32'(k - 1) : $urandom);
  endtask

  initial begin
    bus.itrig = 1'b0; bus.istart_rd = 1'b0; bus.itrig_data = '0; bus.ird_ready = 1'b1;
    for (int k = 0; k < CH; k++) bus.ich_data[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Scan record readout
    idle(16);
    applyStimulus(0, 1, $urandom);
    waitScan("t1_done");
    checkOutput("t1_count", 32'(gotQ.size()), 8);
    if (gotQ.size() == 8) begin
      checkOutput("t1_word0", gotQ[0], 32'h5C00_0AFA);
      checkOutput("t1_word2", gotQ[2], 32'h5C01_0AFA);
      checkOutput("t1_word7", gotQ[7], 32'hC0DE_0003);
    end

    // Capture with counting samples
    capture(1);
    checkOutput("t2_hold_ready", 32'(bus.ocap_ready), 1);
    applyStimulus(0, 1, $urandom);
    waitScan("t2_done");
    checkOutput("t2_count", 32'(gotQ.size()), 9);
    if (gotQ.size() == 9) begin
      checkOutput("t2_hdr", gotQ[0], 32'hCA00_0AFA);
      checkOutput("t2_first", gotQ[1], 32'd1);
      checkOutput("t2_last", gotQ[8], 32'd8);
    end

    // Backpressure on both record types
    randReady = 1;
    idle(16);
    applyStimulus(0, 1, $urandom);
    waitScan("t3_scan_done");
    checkOutput("t3_scan_count", 32'(gotQ.size()), 8);
    capture(0);
    applyStimulus(0, 1, $urandom);
    waitScan("t3_cap_done");
    checkOutput("t3_cap_count", 32'(gotQ.size()), 9);
    randReady = 0;

    // Dropped triggers
    applyStimulus(1, 0, $urandom);
    idle(2);
    applyStimulus(1, 0, $urandom);
    idle(DEPTH + 2);
    applyStimulus(0, 1, $urandom);
    idle(2);
    applyStimulus(1, 0, $urandom);
    waitScan("t4_done");
    checkOutput("t4_drops", 32'(bus.odrop_cnt), 2);
    checkOutput("t4_count", 32'(gotQ.size()), 9);
    applyStimulus(1, 1, $urandom);
    idle(DEPTH + 4);
    checkOutput("t4_trig_wins", 32'(bus.ocap_ready), 1);
    checkOutput("t4_no_read", 32'(bus.obusy), 0);
    applyStimulus(0, 1, $urandom);
    waitScan("t4_read_done");

    // Reset in the middle of a readout
    idle(16);
    applyStimulus(0, 1, $urandom);
    for (int n = 0; n < 40 && gotQ.size() < 3; n++) applyStimulus(0, 0, $urandom);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_valid", 32'(bus.ord_valid), 0);
    checkOutput("t5_data", bus.ord_data, 0);
    checkOutput("t5_last", 32'(bus.ord_last), 0);
    checkOutput("t5_cap", 32'(bus.ocap_ready), 0);
    checkOutput("t5_busy", 32'(bus.obusy), 0);
    checkOutput("t5_drops", 32'(bus.odrop_cnt), 0);
    idle(2);
    rst_n = 1'b1;
    idle(16);
    applyStimulus(0, 1, $urandom);
    waitScan("t5_restart_done");
    checkOutput("t5_restart_count", 32'(gotQ.size()), 8);

    // Long hold must not let scan overwrite the capture record
    capture(0);
    idle(100);
    applyStimulus(0, 1, $urandom);
    waitScan("t6_done");
    checkOutput("t6_count", 32'(gotQ.size()), 9);
    if (gotQ.size() == 9) checkOutput("t6_hdr", gotQ[0], 32'hCA00_0AFA);

    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
